// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// cache_ctrl : two-requester round-robin sequencer for a write-through cache
// Revision   : 1.0
// ============================================================================
module cache_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int LINE_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*LINE_WIDTH-1:0] req_wdata,
   output logic [1:0]              req_ready,
   output logic [1:0]              resp_valid,
   output logic [LINE_WIDTH-1:0]   resp_data,
   output logic [ADDR_WIDTH-1:0]   c_addr,
   output logic [LINE_WIDTH-1:0]   c_val,
   output logic                    c_read,
   output logic                    c_write,
   input  logic                    c_hit,
   input  logic [LINE_WIDTH-1:0]   c_out_val,
   output logic                    mem_req,
   output logic                    mem_write,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [LINE_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_ack,
   input  logic [LINE_WIDTH-1:0]   mem_rdata
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      CHECK  = 3'd2,
      MREAD  = 3'd3,
      FILL   = 3'd4,
      WMEM   = 3'd5,
      RESP   = 3'd6
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
   logic [LINE_WIDTH-1:0]   data_q, data_d;
   logic                    write_q, write_d;
   logic                    id_q, id_d;
   logic                    last_grant_q, last_grant_d;

   logic                    grant_id;
   logic                    accept;
   logic [1:0]              id_onehot;

   // On a tie the requester not served last wins; a lone requester always wins.
   always_comb begin
      if (req_valid == 2'b11) begin
         grant_id = ~last_grant_q;
      end else begin
         grant_id = req_valid[1];
      end
      accept    = !reset && (state_q == IDLE) && (|req_valid);
      id_onehot = id_q ? 2'b10 : 2'b01;
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      data_d       = data_q;
      write_d      = write_q;
      id_d         = id_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d       = grant_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                       : req_addr[ADDR_WIDTH-1:0];
               wdata_d      = grant_id ? req_wdata[2*LINE_WIDTH-1:LINE_WIDTH]
                                       : req_wdata[LINE_WIDTH-1:0];
               write_d      = grant_id ? req_write[1] : req_write[0];
               id_d         = grant_id;
               last_grant_d = grant_id;
               state_d      = LOOKUP;
            end
         end
         LOOKUP:  state_d = write_q ? WMEM : CHECK;
         CHECK:   state_d = c_hit ? IDLE : MREAD;
         MREAD: begin
            if (mem_ack) begin
               data_d  = mem_rdata;
               state_d = FILL;
            end
         end
         FILL:    state_d = RESP;
         WMEM: begin
            if (mem_ack) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         data_q       <= '0;
         write_q      <= 1'b0;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         data_q       <= data_d;
         write_q      <= write_d;
         id_q         <= id_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Outputs decode the current state; everything is forced low while in reset.
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      resp_data  = '0;
      c_addr     = '0;
      c_val      = '0;
      c_read     = 1'b0;
      c_write    = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (!reset) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  req_ready = grant_id ? 2'b10 : 2'b01;
               end
            end
            LOOKUP: begin
               c_addr = addr_q;
               if (write_q) begin
                  c_write = 1'b1;
                  c_val   = wdata_q;
               end else begin
                  c_read  = 1'b1;
               end
            end
            CHECK: begin
               if (c_hit) begin
                  resp_valid = id_onehot;
                  resp_data  = c_out_val;
               end
            end
            MREAD: begin
               mem_req  = 1'b1;
               mem_addr = addr_q;
            end
            FILL: begin
               c_write = 1'b1;
               c_addr  = addr_q;
               c_val   = data_q;
            end
            WMEM: begin
               mem_req   = 1'b1;
               mem_write = 1'b1;
               mem_addr  = addr_q;
               mem_wdata = wdata_q;
            end
            RESP: begin
               resp_valid = id_onehot;
               resp_data  = write_q ? wdata_q : data_q;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cache_ctrl : randomized bench with cache/memory responders and a
//                 transaction-timeline reference model for cache_ctrl
// Revision      : 1.0
// ============================================================================
module tb_cache_ctrl;
   localparam int AW = 8;
   localparam int LW = 32;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic [1:0]      req_valid = '0;
   logic [1:0]      req_write = '0;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*LW-1:0] req_wdata = '0;
   logic [1:0]      req_ready;
   logic [1:0]      resp_valid;
   logic [LW-1:0]   resp_data;
   logic [AW-1:0]   c_addr;
   logic [LW-1:0]   c_val;
   logic            c_read;
   logic            c_write;
   logic            c_hit = 1'b0;
   logic [LW-1:0]   c_out_val = '0;
   logic            mem_req;
   logic            mem_write;
   logic [AW-1:0]   mem_addr;
   logic [LW-1:0]   mem_wdata;
   logic            mem_ack = 1'b0;
   logic [LW-1:0]   mem_rdata = '0;

   cache_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
      .c_addr(c_addr), .c_val(c_val), .c_read(c_read), .c_write(c_write),
      .c_hit(c_hit), .c_out_val(c_out_val),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit        wr;
      bit [7:0]  addr;
      bit [31:0] data;
   } item_t;

   item_t     q0[$];
   item_t     q1[$];
   bit [1:0]  hold;
   int        errors = 0;
   int        checks = 0;
   int        cyc = 0;
   int        rst_cnt = 3;
   int        delay_mode = 3;
   bit        rand_mode = 0;

   // environment: backing memory, bench-side cache contents, golden architectural memory
   logic [31:0] golden [256];
   logic [31:0] mem_arr [256];
   logic [31:0] cache_d [256];
   bit          cache_v [256];
   bit          prev_rd;
   bit [7:0]    prev_addr;
   bit          mem_active;
   int          mcnt, mdelay;

   // logs for literal expectations
   int          last_acc_cyc, last_resp_cyc, resp_cnt = 0, memreq_cnt = 0;
   logic [1:0]  last_resp_vec;
   logic [31:0] last_resp_data;
   logic [7:0]  last_cw_addr;
   logic [31:0] last_cw_val;
   bit          glog[$];

   // reference model: one transaction in flight, timeline relative to accept cycle
   bit          m_busy = 0, m_last = 1, m_wr, m_id;
   int          m_t, m_ack;
   bit [7:0]    m_addr;
   bit [31:0]   m_wdata, m_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int r, input bit wr, input bit [7:0] a, input bit [31:0] d);
      item_t it;
      it.wr = wr; it.addr = a; it.data = d;
      if (r == 0) q0.push_back(it); else q1.push_back(it);
   endtask

   task step();
      item_t it;
      logic [1:0] e_rdy, e_rv;
      logic [31:0] e_rd, e_cv, e_md;
      logic [7:0] e_ca, e_ma;
      logic e_cr, e_cw, e_mr, e_mw;
      bit done, ackn, start;
      int g, sn;

      @(posedge clock);
      cyc++;
      #1;
      reset = (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      if (!hold[0] && q0.size() > 0) begin
         it = q0.pop_front();
         req_write[0] = it.wr; req_addr[7:0] = it.addr; req_wdata[31:0] = it.data; hold[0] = 1;
      end
      if (!hold[1] && q1.size() > 0) begin
         it = q1.pop_front();
         req_write[1] = it.wr; req_addr[15:8] = it.addr; req_wdata[63:32] = it.data; hold[1] = 1;
      end
      req_valid = hold;
      if (prev_rd) begin
         c_hit = cache_v[prev_addr]; c_out_val = cache_d[prev_addr];
      end else begin
         c_hit = 1'($urandom); c_out_val = $urandom;
      end
      if (rand_mode && $urandom_range(0, 3) == 0) cache_v[$urandom_range(0, 31)] = 0;
      #1;
      if (mem_req) begin
         if (!mem_active) begin
            mem_active = 1; mcnt = 0;
            mdelay = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
         end else begin
            mcnt++;
         end
         if (mcnt == mdelay) begin
            mem_ack = 1; mem_rdata = mem_arr[mem_addr];
            if (mem_write) mem_arr[mem_addr] = mem_wdata;
         end else begin
            mem_ack = 0; mem_rdata = $urandom;
         end
      end else begin
         mem_active = 0;
         mem_ack = rand_mode && ($urandom_range(0, 7) == 0);
         mem_rdata = $urandom;
      end

      @(negedge clock);
      if (c_write) begin
         cache_v[c_addr] = 1; cache_d[c_addr] = c_val; last_cw_addr = c_addr; last_cw_val = c_val;
      end
      prev_rd = c_read; prev_addr = c_addr;
      if (mem_req) memreq_cnt++;
      if ((req_valid & req_ready) != 0) begin
         last_acc_cyc = cyc; glog.push_back(req_ready[1]);
      end
      if (resp_valid != 0) begin
         last_resp_cyc = cyc; last_resp_vec = resp_valid; last_resp_data = resp_data; resp_cnt++;
      end

      e_rdy = 0; e_rv = 0; e_rd = 0; e_ca = 0; e_cv = 0; e_cr = 0; e_cw = 0;
      e_mr = 0; e_mw = 0; e_ma = 0; e_md = 0; done = 0; ackn = 0; start = 0;
      g = (req_valid == 2'b11) ? (m_last ? 0 : 1) : (req_valid[1] ? 1 : 0);
      if (reset) begin
         start = 0;
      end else if (!m_busy) begin
         if (req_valid != 0) begin
            e_rdy = (g == 1) ? 2'b10 : 2'b01; start = 1;
         end
      end else begin
         sn = cyc - m_t;
         if (sn == 1) begin
            e_ca = m_addr;
            if (m_wr) begin e_cw = 1; e_cv = m_wdata; end else e_cr = 1;
         end else if (!m_wr && sn == 2) begin
            if (c_hit) begin
               e_rv = m_id ? 2'b10 : 2'b01; e_rd = m_data; done = 1;
            end
         end else if (m_ack < 0) begin
            e_mr = 1; e_mw = m_wr; e_ma = m_addr; e_md = m_wr ? m_wdata : 32'h0;
            ackn = mem_ack;
         end else if (!m_wr && cyc == m_ack + 1) begin
            e_cw = 1; e_ca = m_addr; e_cv = m_data;
         end else begin
            e_rv = m_id ? 2'b10 : 2'b01; e_rd = m_wr ? m_wdata : m_data; done = 1;
         end
      end

      checks++;
      if ({req_ready, resp_valid, resp_data, c_addr, c_val, c_read, c_write, mem_req, mem_write, mem_addr, mem_wdata} !==
          {e_rdy, e_rv, e_rd, e_ca, e_cv, e_cr, e_cw, e_mr, e_mw, e_ma, e_md}) begin
         errors++;
         $display("FAIL cycle %0d outputs: got rdy=%b rv=%b rd=%h ca=%h cv=%h cr=%b cw=%b mr=%b mw=%b ma=%h md=%h, expected rdy=%b rv=%b rd=%h ca=%h cv=%h cr=%b cw=%b mr=%b mw=%b ma=%h md=%h",
                  cyc, req_ready, resp_valid, resp_data, c_addr, c_val, c_read, c_write, mem_req, mem_write, mem_addr, mem_wdata,
                  e_rdy, e_rv, e_rd, e_ca, e_cv, e_cr, e_cw, e_mr, e_mw, e_ma, e_md);
      end

      if (reset) begin
         m_busy = 0; m_last = 1;
      end else begin
         if (done) m_busy = 0;
         if (ackn) m_ack = cyc;
         if (start) begin
            m_busy = 1; m_t = cyc; m_id = g[0]; m_last = g[0]; m_ack = -1;
            m_wr = req_write[g]; m_addr = req_addr[g*AW +: AW]; m_wdata = req_wdata[g*LW +: LW];
            if (m_wr) golden[m_addr] = m_wdata;
            m_data = golden[m_addr];
         end
      end
      hold = hold & ~(req_valid & req_ready);
   endtask

   task wait_idle();
      int k;
      k = 0;
      while ((q0.size() > 0 || q1.size() > 0 || hold != 0 || m_busy) && k < 400) begin
         step();
         k++;
      end
      if (k >= 400) chk("idle_timeout", 64'(k), 64'(0));
   endtask

   initial begin
      int base;
      hold = 0;
      for (int i = 0; i < 256; i++) begin
         golden[i] = $urandom; mem_arr[i] = golden[i]; cache_v[i] = 0; cache_d[i] = 0;
      end
      golden[8'h04] = 32'hDEADBEEF; mem_arr[8'h04] = 32'hDEADBEEF;
      cache_v[8'h04] = 1; cache_d[8'h04] = 32'hDEADBEEF;
      golden[8'h11] = 32'h12345678; mem_arr[8'h11] = 32'h12345678;
      golden[8'h33] = 32'h0BADF00D; mem_arr[8'h33] = 32'h0BADF00D;

      // read hit, requested while still in reset
      push(0, 0, 8'h04, 0);
      step();
      chk("reset_ready", 64'(req_ready), 64'h0);
      chk("reset_outs", 64'({resp_valid, c_read, c_write, mem_req}), 64'h0);
      wait_idle();
      chk("hit_data", 64'(last_resp_data), 64'hDEADBEEF);
      chk("hit_id", 64'(last_resp_vec), 64'h1);
      chk("hit_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd2);
      chk("hit_no_mem", 64'(memreq_cnt), 64'd0);

      // read miss, memory acks 3 cycles after mem_req rises
      push(1, 0, 8'h11, 0);
      wait_idle();
      chk("miss_data", 64'(last_resp_data), 64'h12345678);
      chk("miss_id", 64'(last_resp_vec), 64'h2);
      chk("miss_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd8);
      chk("fill_addr", 64'(last_cw_addr), 64'h11);
      chk("fill_val", 64'(last_cw_val), 64'h12345678);

      // write-through
      push(0, 1, 8'h20, 32'hA5A5A5A5);
      wait_idle();
      chk("wr_data", 64'(last_resp_data), 64'hA5A5A5A5);
      chk("wr_id", 64'(last_resp_vec), 64'h1);
      chk("wr_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd6);
      chk("wr_mem", 64'(mem_arr[8'h20]), 64'hA5A5A5A5);
      chk("wr_cache", 64'(cache_d[8'h20]), 64'hA5A5A5A5);

      // zero-wait memory miss
      delay_mode = 0;
      push(0, 0, 8'h33, 0);
      wait_idle();
      chk("zw_data", 64'(last_resp_data), 64'h0BADF00D);
      chk("zw_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd5);

      // arbitration after a fresh reset
      rst_cnt = 1;
      repeat (3) step();
      glog.delete();
      for (int i = 0; i < 4; i++) begin
         push(0, 0, 8'h04, 0);
         push(1, 0, 8'h11, 0);
      end
      wait_idle();
      chk("arb_count", 64'(glog.size()), 64'd8);
      for (int k = 0; k < 8; k++) begin
         if (k < glog.size()) chk("arb_grant", 64'(glog[k]), 64'(k % 2));
      end

      // reset during MREAD
      delay_mode = 6;
      push(0, 0, 8'h40, 0);
      for (int k = 0; k < 20 && !mem_req; k++) step();
      chk("mread_reached", 64'(mem_req), 64'h1);
      base = resp_cnt;
      rst_cnt = 1;
      step();
      step();
      chk("rst_mem_req", 64'(mem_req), 64'h0);
      repeat (8) step();
      chk("rst_no_resp", 64'(resp_cnt), 64'(base));
      glog.delete();
      push(0, 0, 8'h04, 0);
      push(1, 0, 8'h04, 0);
      wait_idle();
      if (glog.size() > 0) chk("rst_tie_grant", 64'(glog[0]), 64'h0);
      else chk("rst_tie_grant_seen", 64'(glog.size()), 64'h2);

      // randomized traffic with random memory latency, spurious acks and evictions
      rand_mode = 1;
      delay_mode = -1;
      for (int n = 0; n < 3000; n++) begin
         if (q0.size() == 0 && $urandom_range(0, 2) == 0)
            push(0, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 31)), $urandom);
         if (q1.size() == 0 && $urandom_range(0, 2) == 0)
            push(1, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 31)), $urandom);
         if (rst_cnt == 0 && m_busy && !m_wr && m_ack < 0 && (cyc - m_t) >= 3 && $urandom_range(0, 15) == 0)
            rst_cnt = 1;
         step();
      end
      rand_mode = 0;
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
